conv1d_window_mac: RTL and testbench

- Convolution row stage directly downstream of the kernel-parameter loader.
- Waits for the loader's done, captures its packed kernel vector once, then streams input pixels through a SIZE-tap sliding window.
- Emits one signed dot product per full window over a valid/ready handshake to the next stage (accumulator/pooling).
- Integer datapath only.

---
 rtl/conv1d_window_mac.sv | 163 ++++++++++++++++
 tb/tb_conv1d_window_mac.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_window_mac.sv
// rtl/conv1d_window_mac.sv - SIZE-tap sliding-window signed MAC with a 2-stage valid/ready pipeline
// Optional macro RELU_EN: clamp negative results to zero in the output stage.
module conv1d_window_mac #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 3,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH*SIZE-1:0]   ker_map,
  input  logic                    ker_done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    busy
);

  localparam int CNT_W  = $clog2(SIZE + 1);
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_load;

  logic signed [WIDTH-1:0]  r_ker       [SIZE];
  logic signed [WIDTH-1:0]  r_win       [SIZE];
  logic signed [WIDTH-1:0]  w_win_shift [SIZE];
  logic signed [PROD_W-1:0] w_prod      [SIZE];
  logic signed [PROD_W-1:0] r_prod      [SIZE];
  logic [CNT_W-1:0]         r_fill;
  logic [CNT_W-1:0]         w_fill_inc;

  logic                     w_advance;
  logic                     w_accept;
  logic                     w_complete;
  logic                     r_s1_valid;
  logic                     r_out_valid;
  logic [ACC_W-1:0]         r_out_data;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ker_done) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // The whole pipeline moves only when the output register is free or being drained.
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = (r_state == ST_RUN) && w_advance;
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    for (int k = 0; k < SIZE - 1; k++) begin
      w_win_shift[k] = r_win[k+1];
    end
    w_win_shift[SIZE-1] = in_data;
  end

  assign w_fill_inc = (r_fill == CNT_W'(SIZE)) ? r_fill : r_fill + CNT_W'(1);
  assign w_complete = (w_fill_inc == CNT_W'(SIZE));

  always_comb begin
    for (int k = 0; k < SIZE; k++) begin
      w_prod[k] = PROD_W'(r_ker[k]) * PROD_W'(w_win_shift[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SIZE; k++) begin
        r_ker[k] <= '0;
      end
    end else if (w_load) begin
      for (int k = 0; k < SIZE; k++) begin
        r_ker[k] <= ker_map[(SIZE-1-k)*WIDTH +: WIDTH];
      end
    end
  end

  // A row end clears the window so the next row never mixes with this one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SIZE; k++) begin
        r_win[k] <= '0;
      end
      r_fill <= '0;
    end else if (w_accept) begin
      if (in_last) begin
        for (int k = 0; k < SIZE; k++) begin
          r_win[k] <= '0;
        end
        r_fill <= '0;
      end else begin
        r_win  <= w_win_shift;
        r_fill <= w_fill_inc;
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < SIZE; k++) begin
      w_sum = w_sum + ACC_W'(r_prod[k]);
    end
`ifdef RELU_EN
    w_result = w_sum[ACC_W-1] ? '0 : w_sum;
`else
    w_result = w_sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SIZE; k++) begin
        r_prod[k] <= '0;
      end
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_advance) begin
      r_prod      <= w_prod;
      r_s1_valid  <= w_accept && w_complete;
      r_out_valid <= r_s1_valid;
      r_out_data  <= w_result;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state == ST_RUN);

endmodule

// File: tb/tb_conv1d_window_mac.sv
// tb/tb_conv1d_window_mac.sv - scoreboard bench for conv1d_window_mac
module tb_conv1d_window_mac;

  localparam int WIDTH = 8;
  localparam int SIZE  = 3;
  localparam int ACC_W = 18;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [WIDTH*SIZE-1:0] ker_map;
  logic                  ker_done;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_data;
  logic                  busy;

  always #5 clk = ~clk;

  conv1d_window_mac #(.WIDTH(WIDTH), .SIZE(SIZE), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ker_map   (ker_map),
    .ker_done  (ker_done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_out = 0;
  int first_cyc = -1;
  int acc_cyc = 0;
  int mk[SIZE];
  int row[$];
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [ACC_W-1:0] model_dot();
    int s;
    s = 0;
    for (int k = 0; k < SIZE; k++) begin
      s += mk[k] * row[row.size() - SIZE + k];
    end
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    return ACC_W'(s);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (first_cyc < 0) first_cyc = cyc;
      if (out_ready) begin
        checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%0h expected=none", out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_data !== mon_exp) begin
            errors++;
            $display("FAIL out_data got=%0h expected=%0h", out_data, mon_exp);
          end
        end
      end
    end
  end

  task automatic send_pixel(input int d, input bit last);
    int t;
    in_valid = 1'b1;
    in_data  = d[WIDTH-1:0];
    in_last  = last;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=in_ready_low expected=accept");
    end else begin
      acc_cyc = cyc;
      row.push_back(d);
      if (row.size() >= SIZE) exp_q.push_back(model_dot());
      if (last) row.delete();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got=%0d pending expected=0", name, exp_q.size());
    end
  endtask

  task automatic load_kernel(input logic [WIDTH*SIZE-1:0] map);
    logic signed [WIDTH-1:0] tap;
    ker_map  = map;
    ker_done = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_before_load got=%b expected=0", busy);
    end
    @(posedge clk);
    #1;
    ker_done = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_load got=%b expected=1", busy);
    end
    for (int k = 0; k < SIZE; k++) begin
      tap   = map[(SIZE-1-k)*WIDTH +: WIDTH];
      mk[k] = tap;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    row.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b expected=0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%0h expected=0", out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_idle_wait();
    n_out    = 0;
    ker_done = 1'b0;
    ker_map  = 24'h010101;
    in_valid = 1'b1;
    in_data  = 8'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_wait got=rdy%b busy%b ov%b expected=000", in_ready, busy, out_valid);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (n_out != 0) begin errors++; $display("FAIL idle_outputs got=%0d expected=0", n_out); end
    load_kernel(24'h010101);
  endtask

  task automatic test_basic();
    int p3;
    n_out     = 0;
    first_cyc = -1;
    p3        = 0;
    ker_map   = 24'hFFFFFF;
    for (int i = 1; i <= 5; i++) begin
      send_pixel(i, i == 5);
      if (i == 3) p3 = acc_cyc;
    end
    drain("basic");
    checks += 2;
    if (n_out != 3) begin errors++; $display("FAIL basic_count got=%0d expected=3", n_out); end
    if (first_cyc - p3 != 2) begin errors++; $display("FAIL basic_latency got=%0d expected=2", first_cyc - p3); end
  endtask

  task automatic test_row_boundary();
    n_out = 0;
    send_pixel(10, 1'b0);
    send_pixel(20, 1'b1);
    send_pixel(1, 1'b0);
    send_pixel(1, 1'b0);
    send_pixel(1, 1'b1);
    drain("row");
    checks++;
    if (n_out != 1) begin errors++; $display("FAIL row_count got=%0d expected=1", n_out); end
  endtask

  task automatic test_stall();
    n_out     = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) send_pixel(i, i == 6);
      end
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
          t++;
          @(negedge clk);
        end
        if (!out_valid) begin
          checks++;
          errors++;
          $display("FAIL stall_wait got=no_out_valid expected=out_valid");
        end
        for (int i = 0; i < 5; i++) begin
          @(posedge clk);
          #1;
          checks++;
          if (out_data !== 18'd6 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got=%0h rdy%b ov%b expected=6 rdy0 ov1", out_data, in_ready, out_valid);
          end
        end
        out_ready = 1'b1;
      end
    join
    drain("stall");
    checks++;
    if (n_out != 4) begin errors++; $display("FAIL stall_count got=%0d expected=4", n_out); end
  endtask

  task automatic test_reset_mid();
    int t;
    n_out     = 0;
    out_ready = 1'b0;
    send_pixel(1, 1'b0);
    send_pixel(2, 1'b0);
    send_pixel(3, 1'b0);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL midrst_wait got=%b expected=1", out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b expected=0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b expected=0", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b expected=0", in_ready); end
    rst = 1'b0;
    exp_q.delete();
    row.delete();
    out_ready = 1'b1;
    load_kernel(24'h010101);
    send_pixel(2, 1'b0);
    send_pixel(2, 1'b0);
    send_pixel(2, 1'b1);
    drain("midrst");
    checks++;
    if (n_out != 1) begin errors++; $display("FAIL midrst_count got=%0d expected=1", n_out); end
  endtask

  task automatic test_signed();
    n_out = 0;
    pulse_reset();
    load_kernel(24'h0100FF);
    send_pixel(5, 1'b0);
    send_pixel(3, 1'b0);
    send_pixel(2, 1'b1);
    send_pixel(1, 1'b0);
    send_pixel(2, 1'b0);
    send_pixel(7, 1'b1);
    drain("signed");
    checks++;
    if (n_out != 2) begin errors++; $display("FAIL signed_count got=%0d expected=2", n_out); end
  endtask

  initial begin
    rst       = 1'b1;
    ker_map   = '0;
    ker_done  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_idle_wait();
    test_basic();
    test_row_boundary();
    test_stall();
    test_reset_mid();
    test_signed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
